// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline buffers: state encodings,
// default bundle widths and control-field bit positions used to pack/unpack ctrl.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    localparam int DATA_W_DEF = 106;
    localparam int CTRL_W_DEF = 16;
    localparam int PC_W_DEF   = 32;

    // All-zero control is a bubble: no register write, no memory write.
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

    localparam int CTRL_REGWE_BIT   = 0;
    localparam int CTRL_DMWE_BIT    = 1;
    localparam int CTRL_ALUCTRL_LSB = 2;
    localparam int CTRL_ALUCTRL_W   = 4;
    localparam int CTRL_SLCTRL_LSB  = 6;
    localparam int CTRL_SLCTRL_W    = 3;
    localparam int CTRL_RESSRC_LSB  = 9;
    localparam int CTRL_RESSRC_W    = 2;
    localparam int CTRL_BRANCH_BIT  = 11;
    localparam int CTRL_JUMP_BIT    = 12;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One {valid,data,ctrl,pc} register; clear wins over load and zeroes every field.
// Latency: 1 cycle load-to-output. No handshake of its own; the owner sequences load/clear.
module pipe_slot #(
    parameter int DATA_W = 106,
    parameter int CTRL_W = 16,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [PC_W-1:0]   d_pc,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [PC_W-1:0]   pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
            pc    <= d_pc;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer with main + skid slot and synchronous flush to a NOP bubble.
// Latency 1 cycle, throughput 1/cycle; in_ready/out_valid are registered, skid absorbs one stall.
// Optional PIPE_STAGE_STATS_EN adds saturating bubble_cnt/stall_cnt outputs.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PC_W-1:0]   out_pc
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    state_t state, state_nxt;

    logic              main_load, main_clr, main_from_skid;
    logic              skid_load, skid_clr;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data, main_d_data;
    logic [CTRL_W-1:0] skid_ctrl, main_d_ctrl;
    logic [PC_W-1:0]   skid_pc, main_d_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        main_load = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_valid && out_ready) begin
                        main_load = 1'b1;
                    end else if (in_valid) begin
                        skid_load = 1'b1;
                        state_nxt = ST_FULL;
                    end else if (out_ready) begin
                        main_clr  = 1'b1;
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Upstream is held off by in_ready=0, so only the drain path matters.
                    if (out_ready) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_nxt      = ST_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    assign main_d_data = main_from_skid ? skid_data : in_data;
    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_pc   = main_from_skid ? skid_pc   : in_pc;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .PC_W(PC_W)) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (main_load),
        .clear  (main_clr),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .d_pc   (main_d_pc),
        .valid  (out_valid),
        .data   (out_data),
        .ctrl   (out_ctrl),
        .pc     (out_pc)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .PC_W(PC_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .clear  (skid_clr),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .d_pc   (in_pc),
        .valid  (skid_valid),
        .data   (skid_data),
        .ctrl   (skid_ctrl),
        .pc     (skid_pc)
    );

    assign in_ready = ~skid_valid;

`ifdef PIPE_STAGE_STATS_EN
    // Counters survive flush on purpose: they profile the stage, not the stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (!out_valid)             bubble_cnt <= sat_inc(bubble_cnt);
            if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: queue-based reference model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_pipe_stage_buf;

    localparam int DATA_W = 106;
    localparam int CTRL_W = 16;
    localparam int PC_W   = 32;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic [PC_W-1:0]   pc;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [PC_W-1:0]   out_pc;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]       bubble_cnt, stall_cnt;
    logic [31:0]       exp_bubble, exp_stall;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    ent_t q[$];
    logic m_acc, m_con;
    ent_t m_head;

    pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_pc    (out_pc)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .bubble_cnt(bubble_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of depth 2 whose capacity is visible a cycle late.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
`ifdef PIPE_STAGE_STATS_EN
            exp_bubble = 0;
            exp_stall  = 0;
`endif
        end else begin
            m_acc = in_valid && (q.size() < 2);
            m_con = (q.size() > 0) && out_ready;
`ifdef PIPE_STAGE_STATS_EN
            if (q.size() == 0) begin
                if (exp_bubble != 32'hFFFF_FFFF) exp_bubble = exp_bubble + 1;
            end else if (!out_ready) begin
                if (exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
            end
`endif
            if (flush) begin
                q.delete();
            end else begin
                if (m_con) void'(q.pop_front());
                if (m_acc) q.push_back('{data: in_data, ctrl: in_ctrl, pc: in_pc});
            end
        end
    end

    always @(negedge clk) begin
        m_head = (q.size() > 0) ? q[0] : '0;
        chk("cyc_out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("cyc_in_ready",  128'(in_ready),  128'(q.size() < 2));
        chk("cyc_out_data",  128'(out_data),  128'(m_head.data));
        chk("cyc_out_ctrl",  128'(out_ctrl),  128'(m_head.ctrl));
        chk("cyc_out_pc",    128'(out_pc),    128'(m_head.pc));
`ifdef PIPE_STAGE_STATS_EN
        chk("cyc_bubble_cnt", 128'(bubble_cnt), 128'(exp_bubble));
        chk("cyc_stall_cnt",  128'(stall_cnt),  128'(exp_stall));
`endif
    end

    // Wait for the next edge, then present new inputs for the following edge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [15:0] ctrl,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_pc     = pc;
        in_ctrl   = ctrl;
        in_data   = {pc, ~pc, pc, 10'h2A5};
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        #1 reset = 1'b0;
        #11 reset = 1'b1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready",  128'(in_ready),  128'd1);

        // Async reset in the middle of FULL.
        drive(1, 32'h3000, 16'h0011, 0, 0);
        drive(1, 32'h3004, 16'h0022, 0, 0);
        drive(1, 32'h3008, 16'h0033, 0, 0);
        chk("t1_full_in_ready", 128'(in_ready), 128'd0);
        chk("t1_full_pc",       128'(out_pc),   128'h3000);
        #2 reset = 1'b0;
        #1;
        chk("t1_rst_out_valid", 128'(out_valid), 128'd0);
        chk("t1_rst_in_ready",  128'(in_ready),  128'd1);
        chk("t1_rst_pc",        128'(out_pc),    128'd0);
        chk("t1_rst_ctrl",      128'(out_ctrl),  128'd0);
        chk("t1_rst_data",      128'(out_data),  128'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("t1_idle_out_valid", 128'(out_valid), 128'd0);

        // Streaming with out_ready held high.
        drive(1, 32'h3000, 16'h0101, 1, 0);
        drive(1, 32'h3004, 16'h0202, 1, 0);
        chk("t2_pc0", 128'(out_pc), 128'h3000);
        chk("t2_ctrl0", 128'(out_ctrl), 128'h0101);
        drive(1, 32'h3008, 16'h0303, 1, 0);
        chk("t2_pc1", 128'(out_pc), 128'h3004);
        chk("t2_rdy1", 128'(in_ready), 128'd1);
        drive(0, 0, 0, 1, 0);
        chk("t2_pc2", 128'(out_pc), 128'h3008);
        chk("t2_vld2", 128'(out_valid), 128'd1);
        drive(0, 0, 0, 1, 0);
        chk("t2_drained", 128'(out_valid), 128'd0);

        // Back-pressure into FULL, hold the next input, then drain in order.
        drive(1, 32'h3000, 16'h0A0A, 0, 0);
        drive(1, 32'h3004, 16'h0B0B, 0, 0);
        drive(1, 32'h3008, 16'h0C0C, 0, 0);
        chk("t3_full_rdy", 128'(in_ready), 128'd0);
        chk("t3_full_pc",  128'(out_pc),   128'h3000);
        drive(1, 32'h3008, 16'h0C0C, 0, 0);
        drive(1, 32'h3008, 16'h0C0C, 1, 0);
        chk("t3_hold_pc", 128'(out_pc), 128'h3000);
        drive(1, 32'h3008, 16'h0C0C, 1, 0);
        chk("t3_pc1", 128'(out_pc), 128'h3004);
        chk("t3_rdy1", 128'(in_ready), 128'd1);
        drive(0, 0, 0, 1, 0);
        chk("t3_pc2", 128'(out_pc), 128'h3008);
        drive(0, 0, 0, 1, 0);
        chk("t3_empty", 128'(out_valid), 128'd0);

        // Flush in FULL with coincident in_valid and out_ready.
        drive(1, 32'h3100, 16'h1111, 0, 0);
        drive(1, 32'h3104, 16'h2222, 0, 0);
        drive(1, 32'h3108, 16'h3333, 1, 1);
        chk("t4_pre_rdy", 128'(in_ready), 128'd0);
        drive(0, 0, 0, 1, 0);
        chk("t4_flush_vld",  128'(out_valid), 128'd0);
        chk("t4_flush_ctrl", 128'(out_ctrl),  128'd0);
        chk("t4_flush_rdy",  128'(in_ready),  128'd1);
        drive(0, 0, 0, 1, 0);
        chk("t4_no_ghost", 128'(out_valid), 128'd0);

        // ONE -> EMPTY must leave a NOP control word behind.
        drive(1, 32'h3200, 16'hFFFF, 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("t5_ctrl_live", 128'(out_ctrl), 128'hFFFF);
        drive(0, 0, 0, 1, 0);
        chk("t5_ctrl_nop", 128'(out_ctrl), 128'h0000);
        chk("t5_vld",      128'(out_valid), 128'd0);

`ifdef PIPE_STAGE_STATS_EN
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 32'h3300, 16'h0001, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1);
        chk("t6_bubble", 128'(bubble_cnt), 128'd5);
        chk("t6_stall",  128'(stall_cnt),  128'd3);
        drive(0, 0, 0, 1, 0);
        chk("t6_flush_bubble", 128'(bubble_cnt), 128'd5);
        chk("t6_flush_stall",  128'(stall_cnt),  128'd3);
        drive(0, 0, 0, 1, 0);
`endif

        @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
